dz_tdr_scan: RTL and testbench
==============================

// Module: dz_tdr_scan
//
// PURPOSE
//   Parametrised DZ11 Transmit Data Register with transmitter scanner, for the 4-line (DZV11) and 8-line (DZ11) builds.
//   Round-robin scans enabled lines for an empty UART transmitter and presents the line number with TRDY.
//   Steers the next low-byte TDR write to that line's UART.
//   Adds a prescaled scan rate, fair resume after a load, master-scan drop in HOLD, and per-line BREAK via the TDR high byte.
//
// PARAMETERS
//   NLINES   8   lines served; legal values 2, 4 or 8 (elaboration error otherwise)
//   SCANDIV  1   clocks per scan step; 1 = scan every clock; legal range 1..256
//   LW       $clog2(NLINES)   line index width (derived localparam)
//
// PORTS
//   clk          in   1       clock; single clock domain
//   rst          in   1       reset, synchronous, active-high
//   clr          in   1       device clear (CSR CLR); same effect as rst
//   devLOBYTE    in   1       bus cycle writes low byte
//   devHIBYTE    in   1       bus cycle writes high byte
//   dzDATAI      in   36      bus write data
//   tdrWRITE     in   1       TDR write strobe (level, may last several clocks)
//   uartTXLOAD   out  NLINES  one-hot UART transmit load
//   uartTXEMPTY  in   NLINES  UART transmitter empty, per line
//   uartTXBRK    out  NLINES  force line to spacing (BREAK), per line
//   csrMSE       in   1       CSR master scan enable
//   tcrLIN       in   NLINES  TCR line enables
//   tdrTLINE     out  3       CSR TLINE field; upper bits zero when LW<3
//   tdrTRDY      out  1       CSR TRDY
//   regTDR       out  16      read value {BRK[7:0], TBUF[7:0]}
//
// BEHAVIOUR
//   Reset (rst|clr, sync): state=SCAN, scan=0, tdrTLINE=0, brk=0, prescaler=0; outputs tdrTRDY=0, uartTXLOAD=0, uartTXBRK=0.
//   tick: prescaler pulse, once every SCANDIV clocks while state==SCAN && csrMSE.
//     Prescaler holds at 0 otherwise. SCANDIV=1 gives tick=1 every clock.
//   SCAN, on tick:
//     tcrLIN[scan] & uartTXEMPTY[scan] -> tdrTLINE<=scan, go to HOLD.
//     Otherwise scan<=scan+1, mod NLINES (NLINES-1 wraps to 0).
//     No tick: hold everything.
//   HOLD:
//     !csrMSE or !tcrLIN[tdrTLINE] -> SCAN; scan is unchanged, so the same line is re-checked first.
//     Else tdrWRITE&devLOBYTE -> WAIT. The release test has priority over a write in the same clock.
//   WAIT:
//     On !(tdrWRITE&devLOBYTE): go to SCAN with scan<=tdrTLINE+1 mod NLINES, so the next scan starts after the serviced line.
//   tdrTRDY = (state!=SCAN), combinational from the state register.
//     Rises 1 clock after a qualifying tick; falls 1 clock after release or after the write ends.
//   uartTXLOAD: one-hot of tdrTLINE while tdrWRITE&devLOBYTE and state is HOLD or WAIT; zero otherwise.
//     Combinational; asserted for the whole strobe.
//     A low-byte write while in SCAN is ignored: no load and no state change.
//   brk: on tdrWRITE&devHIBYTE, brk <= dzDATAI[8+NLINES-1:8]. Bits above NLINES are ignored.
//     Independent of the scanner state. A word write updates brk and loads the UART in the same cycle.
//   uartTXBRK = brk, registered.
//   regTDR = {zero-extended brk to 8 bits, dzTDR_TBUF(dzDATAI)}.
//   Mid-operation rst/clr: returns to SCAN from any state; a load in progress is abandoned and uartTXLOAD drops the next clock.
//
// STRUCTURE
//   dz_pkg:
//     tdr_state_t enum {SCAN, HOLD, WAIT} (2 bits).
//     Field macros dzTDR_TBUF/dzTDR_BRK.
//     Function onehot(idx, n).
//   Sub-module dz_scan_prescale (SCANDIV): counter with clear, enable and tick out.
//   Remaining logic (scanner FSM, load decode, break register) stays in this module.
//
// TESTING
//   1. NLINES=8, SCANDIV=1, MSE=1, LIN=8'h24, EMPTY=8'hFF: TLINE=2 and TRDY after 3 clocks.
//      Low-byte write of 8'h41 -> uartTXLOAD=8'h04 for the strobe.
//      After the strobe ends, next TLINE=5 (fair resume, not 2).
//   2. Wrap: LIN=8'h01, scan starting at 1 -> TLINE=0 after 8 clocks.
//      NLINES=4 build: scan wraps 3->0 and tdrTLINE[2]=0 always.
//   3. Release: in HOLD on line 3, clear LIN[3] in the same clock as a low-byte write.
//      -> state=SCAN, uartTXLOAD still 8'h08 that clock (combinational), TRDY=0 next clock.
//      Repeat with MSE dropped instead of LIN[3] -> same result.
//   4. SCANDIV=4, LIN=8'h80, EMPTY=8'hFF -> TLINE=7 and TRDY after 32 clocks (8 steps x 4).
//   5. Break: high-byte write of 16'h0500 -> uartTXBRK=8'h05 and regTDR[15:8]=8'h05.
//      Scanner state is unchanged. clr -> uartTXBRK=0.
//   6. Assert rst while in WAIT with the strobe still high -> next clock state=SCAN, TRDY=0, uartTXLOAD=0, TLINE=0.

Source files
------------

// File: rtl/dz_tdr_scan_pkg.sv
// rtl/dz_tdr_scan_pkg.sv - shared types, field macros and helpers for the DZ11 TDR scanner
`define dzTDR_TBUF(d) d[7:0]
`define dzTDR_BRK(d) d[15:8]

package dz_tdr_scan_pkg;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } tdr_state_t;

  localparam int TLINE_W = 3;
  localparam int TDR_W   = 16;
  localparam int DATA_W  = 36;

  // One-hot of idx within an n-line build; out-of-range indices give zero.
  function automatic logic [7:0] onehot(input logic [2:0] idx, input int n);
    onehot = 8'h00;
    if (int'(idx) < n) onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/dz_tdr_scan_if.sv
// rtl/dz_tdr_scan_if.sv - bus, UART and CSR signal bundle for the TDR scanner
interface dz_tdr_scan_if
  import dz_tdr_scan_pkg::*;
#(
  parameter int NLINES = 8
);

  logic                devLOBYTE;
  logic                devHIBYTE;
  logic [DATA_W-1:0]   dzDATAI;
  logic                tdrWRITE;
  logic [NLINES-1:0]   uartTXLOAD;
  logic [NLINES-1:0]   uartTXEMPTY;
  logic [NLINES-1:0]   uartTXBRK;
  logic                csrMSE;
  logic [NLINES-1:0]   tcrLIN;
  logic [TLINE_W-1:0]  tdrTLINE;
  logic                tdrTRDY;
  logic [TDR_W-1:0]    regTDR;

  modport master (
    output devLOBYTE, devHIBYTE, dzDATAI, tdrWRITE, uartTXEMPTY, csrMSE, tcrLIN,
    input  uartTXLOAD, uartTXBRK, tdrTLINE, tdrTRDY, regTDR
  );

  modport slave (
    input  devLOBYTE, devHIBYTE, dzDATAI, tdrWRITE, uartTXEMPTY, csrMSE, tcrLIN,
    output uartTXLOAD, uartTXBRK, tdrTLINE, tdrTRDY, regTDR
  );

endinterface

// File: rtl/dz_scan_prescale.sv
// rtl/dz_scan_prescale.sv - scan-rate prescaler: one tick every SCANDIV enabled clocks
module dz_scan_prescale #(
  parameter int SCANDIV = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (SCANDIV > 1) ? $clog2(SCANDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCANDIV - 1);

  logic [CW-1:0] cnt;

  // With SCANDIV=1 the counter sits at zero and tick simply follows en.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dz_tdr_scan.sv
// rtl/dz_tdr_scan.sv - DZ11 transmit data register with round-robin transmitter scanner
module dz_tdr_scan
  import dz_tdr_scan_pkg::*;
#(
  parameter int NLINES  = 8,
  parameter int SCANDIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  dz_tdr_scan_if.slave bus
);

  localparam int LW = $clog2(NLINES);

  generate
    if (!(NLINES == 2 || NLINES == 4 || NLINES == 8)) begin : g_bad_nlines
      $error("dz_tdr_scan: NLINES must be 2, 4 or 8");
    end
    if (SCANDIV < 1 || SCANDIV > 256) begin : g_bad_scandiv
      $error("dz_tdr_scan: SCANDIV must be in 1..256");
    end
  endgenerate

  tdr_state_t         state, state_n;
  logic [LW-1:0]      scan, scan_n;
  logic [LW-1:0]      tline, tline_n;
  logic [NLINES-1:0]  brk;
  logic [7:0]         brk_field;
  logic [7:0]         oh;
  logic               srst;
  logic               tick;
  logic               wr_lo;
  logic               wr_hi;
  logic               unused_bits;

  assign srst  = rst | clr;
  assign wr_lo = bus.tdrWRITE & bus.devLOBYTE;
  assign wr_hi = bus.tdrWRITE & bus.devHIBYTE;

  dz_scan_prescale #(.SCANDIV(SCANDIV)) u_prescale (
    .clk  (clk),
    .clr  (srst),
    .en   ((state == SCAN) && bus.csrMSE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= SCAN;
      scan  <= '0;
      tline <= '0;
    end else begin
      state <= state_n;
      scan  <= scan_n;
      tline <= tline_n;
    end
  end

  // NLINES is a power of two, so the +1 wraps NLINES-1 back to 0 on its own.
  always_comb begin
    state_n = state;
    scan_n  = scan;
    tline_n = tline;
    case (state)
      SCAN: begin
        if (tick) begin
          if (bus.tcrLIN[scan] && bus.uartTXEMPTY[scan]) begin
            tline_n = scan;
            state_n = HOLD;
          end else begin
            scan_n = scan + LW'(1);
          end
        end
      end
      HOLD: begin
        // Release wins over a write landing in the same clock; scan still points at tline.
        if (!bus.csrMSE || !bus.tcrLIN[tline]) begin
          state_n = SCAN;
        end else if (wr_lo) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (!wr_lo) begin
          state_n = SCAN;
          scan_n  = tline + LW'(1);
        end
      end
      default: begin
        state_n = SCAN;
      end
    endcase
  end

  assign brk_field = `dzTDR_BRK(bus.dzDATAI);

  always_ff @(posedge clk) begin
    if (srst) begin
      brk <= '0;
    end else if (wr_hi) begin
      brk <= brk_field[NLINES-1:0];
    end
  end

  assign oh             = onehot(3'(tline), NLINES);
  assign bus.uartTXLOAD = ((state != SCAN) && wr_lo) ? oh[NLINES-1:0] : '0;
  assign bus.uartTXBRK  = brk;
  assign bus.tdrTRDY    = (state != SCAN);
  assign bus.tdrTLINE   = 3'(tline);
  assign bus.regTDR     = {8'(brk), `dzTDR_TBUF(bus.dzDATAI)};

  assign unused_bits = ^{bus.dzDATAI, brk_field, oh};

endmodule

// File: tb/tb_dz_tdr_scan.sv
// tb/tb_dz_tdr_scan.sv - directed vector bench for dz_tdr_scan (8-line, 4-line and prescaled builds)
module tb_dz_tdr_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, clr8, rst4, clr4, rstd, clrd;

  dz_tdr_scan_if #(.NLINES(8)) b8 ();
  dz_tdr_scan_if #(.NLINES(4)) b4 ();
  dz_tdr_scan_if #(.NLINES(8)) bd ();

  dz_tdr_scan #(.NLINES(8), .SCANDIV(1)) u8 (.clk(clk), .rst(rst8), .clr(clr8), .bus(b8.slave));
  dz_tdr_scan #(.NLINES(4), .SCANDIV(1)) u4 (.clk(clk), .rst(rst4), .clr(clr4), .bus(b4.slave));
  dz_tdr_scan #(.NLINES(8), .SCANDIV(4)) ud (.clk(clk), .rst(rstd), .clr(clrd), .bus(bd.slave));

  typedef struct {
    logic        rs;
    logic        cl;
    logic        mse;
    logic [7:0]  lin;
    logic        wr;
    logic        lo;
    logic        hi;
    logic [15:0] dat;
    logic        e_trdy;
    logic [2:0]  e_tline;
    logic [7:0]  e_load;
    logic [7:0]  e_brk;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic rs, cl, mse, input logic [7:0] lin, input logic wr, lo, hi,
                     input logic [15:0] dat, input logic trdy, input logic [2:0] tl,
                     input logic [7:0] ld, br);
    vec_t v;
    v.rs = rs; v.cl = cl; v.mse = mse; v.lin = lin; v.wr = wr; v.lo = lo; v.hi = hi;
    v.dat = dat; v.e_trdy = trdy; v.e_tline = tl; v.e_load = ld; v.e_brk = br;
    vq.push_back(v);
  endtask

  function automatic logic get_trdy(input int sel);
    case (sel)
      8:       return b8.tdrTRDY;
      4:       return b4.tdrTRDY;
      default: return bd.tdrTRDY;
    endcase
  endfunction

  function automatic logic [2:0] get_tline(input int sel);
    case (sel)
      8:       return b8.tdrTLINE;
      4:       return b4.tdrTLINE;
      default: return bd.tdrTLINE;
    endcase
  endfunction

  // Counts clocks until TRDY is seen; gives up after 200 (the caller's check then fails).
  task automatic wait_trdy(input int sel, output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (get_trdy(sel)) break;
    end
  endtask

  initial begin
    rst8 = 1'b1; clr8 = 1'b0; rst4 = 1'b1; clr4 = 1'b0; rstd = 1'b1; clrd = 1'b0;
    b8.devLOBYTE = 0; b8.devHIBYTE = 0; b8.dzDATAI = '0; b8.tdrWRITE = 0;
    b8.uartTXEMPTY = 8'hFF; b8.csrMSE = 1; b8.tcrLIN = 8'h24;
    b4.devLOBYTE = 0; b4.devHIBYTE = 0; b4.dzDATAI = '0; b4.tdrWRITE = 0;
    b4.uartTXEMPTY = 4'hF; b4.csrMSE = 1; b4.tcrLIN = 4'h0;
    bd.devLOBYTE = 0; bd.devHIBYTE = 0; bd.dzDATAI = '0; bd.tdrWRITE = 0;
    bd.uartTXEMPTY = 8'hFF; bd.csrMSE = 1; bd.tcrLIN = 8'h80;

    // Expected outputs are those seen while each vector's inputs are applied, before the clock consumes them.
    add(1,0,1,8'h24,0,0,0,16'h0000, 0,3'd0,8'h00,8'h00);
    for (int i = 0; i < 3; i++) add(0,0,1,8'h24,0,0,0,16'h0000, 0,3'd0,8'h00,8'h00);
    add(0,0,1,8'h24,0,0,0,16'h0000, 1,3'd2,8'h00,8'h00);
    add(0,0,1,8'h24,1,1,0,16'h0041, 1,3'd2,8'h04,8'h00);
    add(0,0,1,8'h24,1,1,0,16'h0041, 1,3'd2,8'h04,8'h00);
    add(0,0,1,8'h24,0,0,0,16'h0000, 1,3'd2,8'h00,8'h00);
    for (int i = 0; i < 3; i++) add(0,0,1,8'h24,0,0,0,16'h0000, 0,3'd2,8'h00,8'h00);
    add(0,0,1,8'h24,0,0,0,16'h0000, 1,3'd5,8'h00,8'h00);
    add(0,0,1,8'h08,0,0,0,16'h0000, 1,3'd5,8'h00,8'h00);
    for (int i = 0; i < 7; i++) add(0,0,1,8'h08,0,0,0,16'h0000, 0,3'd5,8'h00,8'h00);
    add(0,0,1,8'h08,0,0,0,16'h0000, 1,3'd3,8'h00,8'h00);
    add(0,0,1,8'h00,1,1,0,16'h0042, 1,3'd3,8'h08,8'h00);
    add(0,0,1,8'h08,0,0,0,16'h0000, 0,3'd3,8'h00,8'h00);
    add(0,0,1,8'h08,0,0,0,16'h0000, 1,3'd3,8'h00,8'h00);
    add(0,0,0,8'h08,1,1,0,16'h0043, 1,3'd3,8'h08,8'h00);
    add(0,0,0,8'h08,0,0,0,16'h0000, 0,3'd3,8'h00,8'h00);
    add(0,0,0,8'h08,1,1,0,16'h0044, 0,3'd3,8'h00,8'h00);
    add(0,0,1,8'h08,0,0,0,16'h0000, 0,3'd3,8'h00,8'h00);
    add(0,0,1,8'h08,0,0,0,16'h0000, 1,3'd3,8'h00,8'h00);
    add(0,0,1,8'h08,1,0,1,16'h0500, 1,3'd3,8'h00,8'h00);
    add(0,0,1,8'h08,0,0,0,16'h0500, 1,3'd3,8'h00,8'h05);
    add(0,0,1,8'h08,1,1,1,16'h0342, 1,3'd3,8'h08,8'h05);
    add(0,0,1,8'h08,0,0,0,16'h0000, 1,3'd3,8'h00,8'h03);
    add(0,1,1,8'h08,0,0,0,16'h0000, 0,3'd3,8'h00,8'h03);
    for (int i = 0; i < 4; i++) add(0,0,1,8'h08,0,0,0,16'h0000, 0,3'd0,8'h00,8'h00);
    add(0,0,1,8'h08,1,1,0,16'h0045, 1,3'd3,8'h08,8'h00);
    add(1,0,1,8'h08,1,1,0,16'h0045, 1,3'd3,8'h08,8'h00);
    add(0,0,1,8'h08,1,1,0,16'h0045, 0,3'd0,8'h00,8'h00);

    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      rst8 = vq[i].rs; clr8 = vq[i].cl;
      b8.csrMSE = vq[i].mse; b8.tcrLIN = vq[i].lin;
      b8.tdrWRITE = vq[i].wr; b8.devLOBYTE = vq[i].lo; b8.devHIBYTE = vq[i].hi;
      b8.dzDATAI = {20'h0, vq[i].dat};
      #3;
      chk("trdy",  i, 32'(b8.tdrTRDY),    32'(vq[i].e_trdy));
      chk("tline", i, 32'(b8.tdrTLINE),   32'(vq[i].e_tline));
      chk("load",  i, 32'(b8.uartTXLOAD), 32'(vq[i].e_load));
      chk("txbrk", i, 32'(b8.uartTXBRK),  32'(vq[i].e_brk));
      chk("regtdr", i, 32'(b8.regTDR),    32'({vq[i].e_brk, vq[i].dat[7:0]}));
    end

    // 8-line wrap: parked on line 1, then only line 0 enabled.
    @(posedge clk);
    #1;
    rst8 = 1'b1; b8.tdrWRITE = 0; b8.devLOBYTE = 0; b8.devHIBYTE = 0; b8.tcrLIN = 8'h02;
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    wait_trdy(8, n);
    chk("wrap8_hold_clks", 0, 32'(n), 32'd2);
    chk("wrap8_hold_line", 0, 32'(get_tline(8)), 32'd1);
    b8.tcrLIN = 8'h01;
    @(posedge clk);
    #1;
    chk("wrap8_release", 0, 32'(b8.tdrTRDY), 32'd0);
    wait_trdy(8, n);
    chk("wrap8_clks", 0, 32'(n), 32'd8);
    chk("wrap8_line", 0, 32'(get_tline(8)), 32'd0);

    // 4-line build: wrap 3->0 and TLINE upper bit stays clear.
    b4.tcrLIN = 4'h2;
    rst4 = 1'b0;
    wait_trdy(4, n);
    chk("wrap4_hold_clks", 0, 32'(n), 32'd2);
    chk("wrap4_hold_line", 0, 32'(b4.tdrTLINE), 32'd1);
    b4.tcrLIN = 4'h1;
    @(posedge clk);
    #1;
    chk("wrap4_release", 0, 32'(b4.tdrTRDY), 32'd0);
    wait_trdy(4, n);
    chk("wrap4_clks", 0, 32'(n), 32'd4);
    chk("wrap4_line", 0, 32'(b4.tdrTLINE), 32'd0);
    b4.tcrLIN = 4'h8;
    wait_trdy(4, n);
    chk("wrap4_l3_clks", 0, 32'(n), 32'd5);
    chk("wrap4_l3_line", 0, 32'(b4.tdrTLINE), 32'd3);

    // Prescaled scan: eight steps of four clocks each to reach line 7.
    rstd = 1'b0;
    wait_trdy(1, n);
    chk("div4_clks", 0, 32'(n), 32'd32);
    chk("div4_line", 0, 32'(bd.tdrTLINE), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
